// File: rtl/voxel_ram_sched.sv
// rtl/voxel_ram_sched.sv - mode sequencer and arbiter owning the single voxel occupancy RAM port
// Multiplexes the clear engine, host load writes and raycast reads; RAM strobes are registered.
module voxel_ram_sched #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned RD_LAT    = 1,
  parameter logic        CLEAR_VAL = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_clear,
  input  logic              cmd_load,
  input  logic              cmd_run,
  input  logic              cmd_stop,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  output logic              rsp_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  input  logic              ram_rdata,
  output logic [2:0]        state_o,
  output logic              clear_done,
  output logic              scene_ready,
  output logic [ADDR_W:0]   load_count,
  output logic              err_sticky
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   LC_MAX    = {1'b1, {ADDR_W{1'b0}}};
  // Every pipe stage except the last still owes a future response.
  localparam logic [RD_LAT-1:0] PEND_MASK = {RD_LAT{1'b1}} >> 1;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic [RD_LAT-1:0]   r_pipe;
  logic                r_ram_en;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic                r_ram_wdata;
  logic                r_clear_done;
  logic                r_scene_ready;
  logic [ADDR_W:0]     r_load_count;
  logic                r_err;

  logic w_rd_strobe;
  logic w_pending;

  assign w_rd_strobe = r_ram_en & ~r_ram_we;
  assign w_pending   = w_rd_strobe | (|(r_pipe & PEND_MASK));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_clr_addr    <= '0;
      r_pipe        <= '0;
      r_ram_en      <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_wdata   <= 1'b0;
      r_clear_done  <= 1'b0;
      r_scene_ready <= 1'b0;
      r_load_count  <= '0;
      r_err         <= 1'b0;
    end else begin
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_clear_done <= 1'b0;

      r_pipe[0] <= w_rd_strobe;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end

      if (ld_valid && r_state != S_LOAD) begin
        r_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_clear) begin
            r_state       <= S_CLEAR;
            r_clr_addr    <= '0;
            r_scene_ready <= 1'b0;
          end else if (cmd_load) begin
            r_state       <= S_LOAD;
            r_load_count  <= '0;
            r_scene_ready <= 1'b0;
          end else if (cmd_run) begin
            r_state <= S_RUN;
          end
        end

        S_CLEAR: begin
          r_ram_en    <= 1'b1;
          r_ram_we    <= 1'b1;
          r_ram_addr  <= r_clr_addr;
          r_ram_wdata <= CLEAR_VAL;
          r_clr_addr  <= r_clr_addr + 1'b1;
          if (&r_clr_addr) begin
            r_clear_done <= 1'b1;
            r_state      <= S_IDLE;
          end
        end

        S_LOAD: begin
          if (ld_valid) begin
            r_ram_en    <= 1'b1;
            r_ram_we    <= 1'b1;
            r_ram_addr  <= ld_addr;
            r_ram_wdata <= ld_data;
            if (r_load_count != LC_MAX) begin
              r_load_count <= r_load_count + 1'b1;
            end
          end
          if (cmd_stop) begin
            r_state       <= S_IDLE;
            r_scene_ready <= 1'b1;
          end
        end

        S_RUN: begin
          if (rd_valid) begin
            r_ram_en    <= 1'b1;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= rd_addr;
            r_ram_wdata <= 1'b0;
          end
          if (cmd_stop) begin
            r_state <= (rd_valid || w_pending) ? S_DRAIN : S_IDLE;
          end
        end

        S_DRAIN: begin
          // The last outstanding response may be on rsp_valid right now.
          if (!w_pending) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ld_ready    = (r_state == S_LOAD);
  assign rd_ready    = (r_state == S_RUN);
  assign rsp_valid   = r_pipe[RD_LAT-1];
  assign rsp_data    = r_pipe[RD_LAT-1] & ram_rdata;
  assign ram_en      = r_ram_en;
  assign ram_we      = r_ram_we;
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;
  assign state_o     = r_state;
  assign clear_done  = r_clear_done;
  assign scene_ready = r_scene_ready;
  assign load_count  = r_load_count;
  assign err_sticky  = r_err;

endmodule

// File: tb/tb_voxel_ram_sched.sv
// tb/tb_voxel_ram_sched.sv - directed self-checking bench for voxel_ram_sched
// Includes a 1-cycle-latency behavioural RAM driven by the DUT's RAM port.
module tb_voxel_ram_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_clear = 0, cmd_load = 0, cmd_run = 0, cmd_stop = 0;
  logic        ld_valid = 0, ld_data = 0, rd_valid = 0;
  logic [14:0] ld_addr = '0, rd_addr = '0;
  logic        ld_ready, rd_ready, rsp_valid, rsp_data;
  logic        ram_en, ram_we, ram_wdata;
  logic [14:0] ram_addr;
  logic        ram_rdata = 1'b0;
  logic [2:0]  state_o;
  logic        clear_done, scene_ready, err_sticky;
  logic [15:0] load_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic mem [0:32767];

  voxel_ram_sched #(.ADDR_W(15), .RD_LAT(1), .CLEAR_VAL(1'b0)) dut (
    .clock(clock), .reset(reset),
    .cmd_clear(cmd_clear), .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_stop(cmd_stop),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .state_o(state_o), .clear_done(clear_done), .scene_ready(scene_ready),
    .load_count(load_count), .err_sticky(err_sticky)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    n_tests++;
    if ({state_o, ram_en, ram_we, ld_ready, rd_ready} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got state=%0d en=%b we=%b ldr=%b rdr=%b want all 0",
                         state_o, ram_en, ram_we, ld_ready, rd_ready);
    end
    n_tests++;
    if ({rsp_valid, clear_done, scene_ready, err_sticky, load_count} !== 20'h0) begin
      n_fail++; $display("FAIL reset_status: got rsp=%b cd=%b sr=%b err=%b lc=%0d want all 0",
                         rsp_valid, clear_done, scene_ready, err_sticky, load_count);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_clear;
    int bad = 0;
    cmd_clear = 1'b1;
    tick;
    cmd_clear = 1'b0;
    n_tests++;
    if (state_o !== 3'd1 || ram_en !== 1'b0) begin
      n_fail++; $display("FAIL clear_entry: got state=%0d en=%b want 1/0", state_o, ram_en);
    end
    for (int i = 0; i < 32768; i++) begin
      tick;
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== i[14:0] || ram_wdata !== 1'b0 ||
          clear_done !== (i == 32767))
        bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL clear_sequence: got %0d bad cycles want 0", bad);
    end
    n_tests++;
    if (state_o !== 3'd0) begin
      n_fail++; $display("FAIL clear_exit_state: got %0d want 0", state_o);
    end
    tick;
    n_tests++;
    if (ram_en !== 1'b0 || clear_done !== 1'b0) begin
      n_fail++; $display("FAIL clear_after: got en=%b cd=%b want 0/0", ram_en, clear_done);
    end
  endtask

  task automatic test_load;
    logic [14:0] addrs [3];
    logic        datas [3];
    addrs[0] = 15'h0010; datas[0] = 1'b1;
    addrs[1] = 15'h7FFF; datas[1] = 1'b1;
    addrs[2] = 15'h0000; datas[2] = 1'b0;
    cmd_load = 1'b1;
    tick;
    cmd_load = 1'b0;
    n_tests++;
    if (state_o !== 3'd2 || ld_ready !== 1'b1 || load_count !== 16'd0 || scene_ready !== 1'b0) begin
      n_fail++; $display("FAIL load_entry: got state=%0d ldr=%b lc=%0d sr=%b want 2/1/0/0",
                         state_o, ld_ready, load_count, scene_ready);
    end
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_addr = addrs[i]; ld_data = datas[i];
      cmd_stop = (i == 2);
      tick;
      ld_valid = 1'b0; cmd_stop = 1'b0;
      n_tests++;
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== addrs[i] || ram_wdata !== datas[i] ||
          load_count !== 16'(i + 1)) begin
        n_fail++; $display("FAIL load_write%0d: got en=%b we=%b addr=%h d=%b lc=%0d want 1/1/%h/%b/%0d",
                           i, ram_en, ram_we, ram_addr, ram_wdata, load_count, addrs[i], datas[i], i + 1);
      end
    end
    n_tests++;
    if (state_o !== 3'd0 || ld_ready !== 1'b0 || scene_ready !== 1'b1 || err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL load_stop: got state=%0d ldr=%b sr=%b err=%b want 0/0/1/0",
                         state_o, ld_ready, scene_ready, err_sticky);
    end
    tick;
  endtask

  task automatic test_run;
    cmd_run = 1'b1;
    tick;
    cmd_run = 1'b0;
    n_tests++;
    if (state_o !== 3'd3 || rd_ready !== 1'b1) begin
      n_fail++; $display("FAIL run_entry: got state=%0d rdr=%b want 3/1", state_o, rd_ready);
    end
    rd_valid = 1'b1; rd_addr = 15'h0010;
    tick;
    n_tests++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 15'h0010 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL run_strobe0: got en=%b we=%b addr=%h rsp=%b want 1/0/0010/0",
                         ram_en, ram_we, ram_addr, rsp_valid);
    end
    rd_addr = 15'h7FFF;
    tick;
    n_tests++;
    if (ram_addr !== 15'h7FFF || ram_en !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== 1'b1) begin
      n_fail++; $display("FAIL run_rsp0: got addr=%h en=%b rsp=%b d=%b want 7fff/1/1/1",
                         ram_addr, ram_en, rsp_valid, rsp_data);
    end
    rd_addr = 15'h0001;
    tick;
    rd_valid = 1'b0;
    n_tests++;
    if (ram_addr !== 15'h0001 || ram_en !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== 1'b1) begin
      n_fail++; $display("FAIL run_rsp1: got addr=%h en=%b rsp=%b d=%b want 0001/1/1/1",
                         ram_addr, ram_en, rsp_valid, rsp_data);
    end
    tick;
    n_tests++;
    if (ram_en !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 1'b0) begin
      n_fail++; $display("FAIL run_rsp2: got en=%b rsp=%b d=%b want 0/1/0", ram_en, rsp_valid, rsp_data);
    end
    tick;
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL run_rsp_end: got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_drain;
    rd_valid = 1'b1; rd_addr = 15'h7FFF; cmd_stop = 1'b1;
    tick;
    rd_valid = 1'b0; cmd_stop = 1'b0;
    n_tests++;
    if (state_o !== 3'd4 || rd_ready !== 1'b0 || ram_en !== 1'b1 || ram_we !== 1'b0) begin
      n_fail++; $display("FAIL drain_entry: got state=%0d rdr=%b en=%b we=%b want 4/0/1/0",
                         state_o, rd_ready, ram_en, ram_we);
    end
    tick;
    n_tests++;
    if (state_o !== 3'd4 || rd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 1'b1) begin
      n_fail++; $display("FAIL drain_rsp: got state=%0d rdr=%b rsp=%b d=%b want 4/0/1/1",
                         state_o, rd_ready, rsp_valid, rsp_data);
    end
    tick;
    n_tests++;
    if (state_o !== 3'd0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_exit: got state=%0d rsp=%b want 0/0", state_o, rsp_valid);
    end
    cmd_run = 1'b1;
    tick;
    cmd_run = 1'b0; cmd_stop = 1'b1;
    tick;
    cmd_stop = 1'b0;
    n_tests++;
    if (state_o !== 3'd0) begin
      n_fail++; $display("FAIL drain_zero: got state=%0d want 0", state_o);
    end
  endtask

  task automatic test_err_and_priority;
    cmd_run = 1'b1;
    tick;
    cmd_run = 1'b0;
    ld_valid = 1'b1; ld_addr = 15'h0010; ld_data = 1'b0;
    tick;
    ld_valid = 1'b0;
    n_tests++;
    if (ram_en !== 1'b0 || err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL err_set: got en=%b err=%b want 0/1", ram_en, err_sticky);
    end
    cmd_stop = 1'b1;
    tick;
    cmd_stop = 1'b0;
    cmd_clear = 1'b1; cmd_load = 1'b1;
    tick;
    cmd_clear = 1'b0; cmd_load = 1'b0;
    n_tests++;
    if (state_o !== 3'd1 || err_sticky !== 1'b1 || scene_ready !== 1'b0) begin
      n_fail++; $display("FAIL prio_clear: got state=%0d err=%b sr=%b want 1/1/0",
                         state_o, err_sticky, scene_ready);
    end
  endtask

  task automatic test_reset_mid_clear;
    int guard = 0;
    while (!(ram_en === 1'b1 && ram_addr === 15'd100) && guard < 300) begin
      tick;
      guard++;
    end
    n_tests++;
    if (guard >= 300) begin
      n_fail++; $display("FAIL midclr_reach: got timeout after %0d cycles want addr 100", guard);
    end
    reset = 1'b1;
    tick;
    n_tests++;
    if (ram_en !== 1'b0 || state_o !== 3'd0 || err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL midclr_abort: got en=%b state=%0d err=%b want 0/0/0",
                         ram_en, state_o, err_sticky);
    end
    reset = 1'b0;
    tick;
    cmd_clear = 1'b1;
    tick;
    cmd_clear = 1'b0;
    tick;
    n_tests++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 15'd0) begin
      n_fail++; $display("FAIL midclr_restart: got en=%b we=%b addr=%0d want 1/1/0",
                         ram_en, ram_we, ram_addr);
    end
    reset = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_clear;
    test_load;
    test_run;
    test_drain;
    test_err_and_priority;
    test_reset_mid_clear;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
